instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage of the single-issue ARM-subset CPU, directly upstream of the instruction decoder. Maintains the program counter and issues word-aligned requests to instruction memory over a variable-latency req/valid handshake. Holds each returned word in an instruction register, presented to the decoder's `instruction_set` input through a valid/ready handshake. Accepts branch redirects from execute, computes the ARM target, and discards any wrong-path fetch still in flight.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset. Bits [1:0] are ignored and treated as 0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `imem_req`  out  1  fetch request, held until `imem_valid`
- `imem_addr`  out  32  fetch address, stable while `imem_req` is high; bits [1:0] = 0
- `imem_valid`  in  1  response strobe for the outstanding request
- `imem_rdata`  in  32  instruction word, sampled when `imem_valid` is high
- `instruction_set`  out  32  held instruction, to decoder
- `inst_pc`  out  32  address of `instruction_set`
- `inst_valid`  out  1  `instruction_set` / `inst_pc` are valid
- `inst_ready`  in  1  downstream accepts the instruction this cycle
- `redirect_valid`  in  1  taken branch, single-cycle pulse
- `redirect_pc`  in  32  address of the taken branch instruction
- `redirect_offset`  in  24  branch field [23:0], signed word offset
- `fetch_count`  out  32  present only with `IFETCH_PERF_EN`
- `stall_count`  out  32  present only with `IFETCH_PERF_EN`

## Operation
- States: IDLE, WAIT_MEM, HOLD, DROP.
- Reset (`rst_n`=0 at an edge):
  - state=IDLE, pc=`RESET_PC`, `imem_req`=0, `inst_valid`=0, `instruction_set`=0, `inst_pc`=0, counters=0.
- IDLE:
  - Next edge goes to WAIT_MEM.
- WAIT_MEM:
  - `imem_req`=1 and `imem_addr`=pc.
  - On `imem_valid`: latch `instruction_set`=`imem_rdata` and `inst_pc`=pc; set pc=pc+4; go to HOLD.
- HOLD:
  - `imem_req`=0, `inst_valid`=1.
  - On `inst_ready`: clear `inst_valid` and go to WAIT_MEM.
  - Otherwise hold all outputs.
- DROP:
  - `imem_req`=0; waits for the response of the abandoned request.
  - On `imem_valid`: discard the data and go to WAIT_MEM.
- Redirect target:
  - target = `redirect_pc` + 8 + (sign-extend(`redirect_offset`) << 2), computed mod 2^32.
  - Bits [1:0] of the result are forced to 0.
- Redirect has priority over every other event. Behaviour by state:
  - IDLE or HOLD: pc=target, `inst_valid`=0 next cycle even if `inst_ready` was high, go to WAIT_MEM.
  - WAIT_MEM, same cycle as `imem_valid`: discard the response, pc=target, go to WAIT_MEM.
  - WAIT_MEM, no `imem_valid`: pc=target, go to DROP.
  - DROP: pc=target, stay in DROP.
- PC increment wraps: 32'hFFFF_FFFC + 4 = 0.
- Only one memory request is ever outstanding.

## Timing
- Request at edge N: `imem_req` is high in cycle N+1.
- A zero-wait memory asserts `imem_valid` in cycle N+1. The instruction register loads at the end of N+1, and `inst_valid` is high in N+2.
- Acceptance in cycle K: the next `imem_req` is high in K+1.
- Steady-state throughput with zero-wait memory and `inst_ready` tied high is 1 instruction per 2 cycles.
- Redirect pulse in cycle R with no request pending: `imem_addr`=target and `imem_req`=1 in R+1.
- `imem_valid` outside WAIT_MEM or DROP is ignored.
- `rst_n` low in any state, including DROP or HOLD, returns every output to its reset value at that edge. A late memory response after reset is ignored unless the block is in WAIT_MEM or DROP.

## Configuration
- `IFETCH_PERF_EN`
  - Defined: adds the `fetch_count` and `stall_count` ports and registers, both saturating at 32'hFFFF_FFFF.
    - `fetch_count` increments on each accepted instruction (`inst_valid` && `inst_ready` && !`redirect_valid`).
    - `stall_count` increments on each cycle with `inst_valid` && !`inst_ready`.
  - Undefined: neither the ports nor the registers exist. Functional behaviour is otherwise identical.

## Structure
- Package `cpu_fetch_pkg` holds:
  - the state enum;
  - the `PC_INC`=4 and `BR_PIPE_OFS`=8 constants;
  - the default `RESET_PC`.
- One sub-module, `ifetch_target`: combinational sign-extend, shift and add producing the 32-bit redirect target. It is reusable by execute for link-address logic.

## Test plan
- Reset release with `RESET_PC`=32'h100 and zero-wait memory: `imem_addr` sequence is 0x100, 0x104, 0x108; `inst_pc` matches each address and `inst_valid` toggles every other cycle.
- `inst_ready` held low for 5 cycles with data 32'hE0875006 held: `instruction_set` stays stable, no new `imem_req` is issued, and `stall_count` = 5 when `IFETCH_PERF_EN` is defined.
- Redirect in HOLD with `redirect_pc`=0x200 and offset 24'hFFFFFE: next `imem_addr` = 0x200; the held instruction is dropped with no acceptance counted.
- Redirect during a 3-cycle memory wait with offset 24'h000004: the stale response is discarded, then a fetch of 0x218 is issued for `redirect_pc`=0x200.
- Redirect coincident with `imem_valid`: the data never appears on `instruction_set`, and the next `imem_addr` equals the target.
- PC wrap and mid-operation reset: fetch from 32'hFFFF_FFFC is followed by 0x0. Asserting `rst_n`=0 in DROP restores pc to `RESET_PC` and clears `inst_valid`.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding,
// PC step, ARM branch pipeline offset and the default reset PC.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_HOLD     = 2'd2,
        ST_DROP     = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] BR_PIPE_OFS      = 32'd8;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_target.sv
// ARM branch target: pc + 8 + (sign-extended 24-bit word offset << 2), word aligned.
// Purely combinational so execute can reuse it for link-address logic.
module ifetch_target
    import cpu_fetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [23:0] i_offset,
    output logic [31:0] o_target
);

    logic [31:0] w_byte_ofs;
    logic [31:0] w_sum;

    assign w_byte_ofs = {{6{i_offset[23]}}, i_offset, 2'b00};
    assign w_sum      = i_pc + BR_PIPE_OFS + w_byte_ofs;
    assign o_target   = {w_sum[31:2], 2'b00};

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single-outstanding imem req/valid handshake, instruction register
// and branch redirect. Optional IFETCH_PERF_EN adds fetch_count / stall_count.
module instruction_fetch
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_set,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
`ifdef IFETCH_PERF_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [23:0] redirect_offset
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_instr;
    logic [31:0]  r_inst_pc;
    logic         w_load_ir;
    logic [31:0]  w_target;

    ifetch_target u_target (
        .i_pc     (redirect_pc),
        .i_offset (redirect_offset),
        .o_target (w_target)
    );

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load_ir   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_WAIT_MEM;
                if (redirect_valid) w_pc_nxt = w_target;
            end
            ST_WAIT_MEM: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = imem_valid ? ST_WAIT_MEM : ST_DROP;
                end else if (imem_valid) begin
                    w_load_ir   = 1'b1;
                    w_pc_nxt    = r_pc + PC_INC;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = ST_WAIT_MEM;
                end else if (inst_ready) begin
                    w_state_nxt = ST_WAIT_MEM;
                end
            end
            ST_DROP: begin
                if (redirect_valid) w_pc_nxt = w_target;
                // The abandoned response retires the outstanding request even when a
                // second redirect lands the same cycle; staying here would wait forever.
                if (imem_valid) w_state_nxt = ST_WAIT_MEM;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC_ALIGNED;
            r_instr   <= '0;
            r_inst_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_load_ir) begin
                r_instr   <= imem_rdata;
                r_inst_pc <= r_pc;
            end
        end
    end

    assign imem_req        = (r_state == ST_WAIT_MEM);
    assign imem_addr       = r_pc;
    assign inst_valid      = (r_state == ST_HOLD);
    assign instruction_set = r_instr;
    assign inst_pc         = r_inst_pc;

`ifdef IFETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;
    logic        w_accept;
    logic        w_stall;

    assign w_accept = inst_valid && inst_ready && !redirect_valid;
    assign w_stall  = inst_valid && !inst_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_accept && (r_fetch_count != 32'hFFFF_FFFF)) r_fetch_count <= r_fetch_count + 32'd1;
            if (w_stall  && (r_stall_count != 32'hFFFF_FFFF)) r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign stall_count = r_stall_count;
`endif

endmodule
